// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register ids and status encodings.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IcodeHalt   = 4'h0;
    localparam logic [3:0] IcodeNop    = 4'h1;
    localparam logic [3:0] IcodeRrmovq = 4'h2;  // also cmovXX
    localparam logic [3:0] IcodeIrmovq = 4'h3;
    localparam logic [3:0] IcodeRmmovq = 4'h4;
    localparam logic [3:0] IcodeMrmovq = 4'h5;
    localparam logic [3:0] IcodeOpq    = 4'h6;
    localparam logic [3:0] IcodeJxx    = 4'h7;
    localparam logic [3:0] IcodeCall   = 4'h8;
    localparam logic [3:0] IcodeRet    = 4'h9;
    localparam logic [3:0] IcodePushq  = 4'hA;
    localparam logic [3:0] IcodePopq   = 4'hB;

    // Register ids
    localparam logic [3:0] RegRsp  = 4'h4;
    localparam logic [3:0] RegNone = 4'hF;
    localparam int unsigned NumRegs = 15;

    // Architectural status
    typedef enum logic [1:0] {
        StatAok = 2'b00,
        StatHlt = 2'b01,
        StatAdr = 2'b10,
        StatIns = 2'b11
    } stat_e;

endpackage

// File: rtl/regfile15.sv
// 15-entry register file: two read ports, two write ports (M wins on collision),
// one debug read port. Id F reads as zero and is never written.
module regfile15
    import y86_pkg::*;
#(
    parameter int unsigned        DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [3:0]        wr_addr_e,
    input  logic [DATA_W-1:0] wr_data_e,
    input  logic [3:0]        wr_addr_m,
    input  logic [DATA_W-1:0] wr_data_m
);

    logic [DATA_W-1:0] regs_q [NumRegs];

    // Register storage; the M write is applied last so it overrides E on the same id
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= (4'(i) == RegRsp) ? RSP_INIT : '0;
            end
        end else if (we) begin
            for (int i = 0; i < NumRegs; i++) begin
                if (wr_addr_e == 4'(i)) regs_q[i] <= wr_data_e;
                if (wr_addr_m == 4'(i)) regs_q[i] <= wr_data_m;
            end
        end
    end

    // Read port A; id F matches no entry and yields zero
    always_comb begin
        rd_data_a = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (rd_addr_a == 4'(i)) rd_data_a = regs_q[i];
        end
    end

    // Read port B
    always_comb begin
        rd_data_b = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (rd_addr_b == 4'(i)) rd_data_b = regs_q[i];
        end
    end

    // Debug read port
    always_comb begin
        dbg_data = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (dbg_addr == 4'(i)) dbg_data = regs_q[i];
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: source/destination selection, register file
// access and the sticky architectural status register.
module decode_writeback
    import y86_pkg::*;
#(
    parameter int unsigned        DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic              dmem_error,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic [1:0]        stat,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    stat_e stat_q;
    stat_e next_stat;
    logic  wr_en;

    // Source A select
    always_comb begin
        case (icode)
            IcodeRrmovq, IcodeRmmovq, IcodeOpq, IcodePushq: srcA = rA;
            IcodeRet, IcodePopq:                            srcA = RegRsp;
            default:                                        srcA = RegNone;
        endcase
    end

    // Source B select
    always_comb begin
        case (icode)
            IcodeRmmovq, IcodeMrmovq, IcodeOpq:           srcB = rB;
            IcodeCall, IcodeRet, IcodePushq, IcodePopq:   srcB = RegRsp;
            default:                                      srcB = RegNone;
        endcase
    end

    // E destination select; cmovXX only writes when the condition holds
    always_comb begin
        case (icode)
            IcodeRrmovq:                                dstE = cnd ? rB : RegNone;
            IcodeIrmovq, IcodeOpq:                      dstE = rB;
            IcodeCall, IcodeRet, IcodePushq, IcodePopq: dstE = RegRsp;
            default:                                    dstE = RegNone;
        endcase
    end

    // M destination select
    always_comb begin
        case (icode)
            IcodeMrmovq, IcodePopq: dstM = rA;
            default:                dstM = RegNone;
        endcase
    end

    // Next status, highest priority first: address fault, invalid instruction, halt
    always_comb begin
        if (imem_error || dmem_error) begin
            next_stat = StatAdr;
        end else if (!instr_valid) begin
            next_stat = StatIns;
        end else if (icode == IcodeHalt) begin
            next_stat = StatHlt;
        end else begin
            next_stat = StatAok;
        end
    end

    // Status register; sticky once it leaves AOK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= StatAok;
        end else if (stat_q == StatAok) begin
            stat_q <= next_stat;
        end
    end

    // The halting or faulting instruction itself must not commit
    always_comb begin
        wr_en = (stat_q == StatAok) && (next_stat == StatAok);
        stat  = stat_q;
    end

    regfile15 #(
        .DATA_W   (DATA_W),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (srcA),
        .rd_data_a (valA),
        .rd_addr_b (srcB),
        .rd_data_b (valB),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .we        (wr_en),
        .wr_addr_e (dstE),
        .wr_data_e (valE),
        .wr_addr_m (dstM),
        .wr_data_m (valM)
    );

endmodule

// File: tb/tb_decode_writeback.sv
// Directed testbench for decode_writeback with hand-computed expectations.
module tb_decode_writeback;

    localparam logic [63:0] RspInit = 64'h0000_0000_0000_0F00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB, dbg_addr;
    logic        instr_valid, imem_error, dmem_error, cnd;
    logic [63:0] valE, valM, valA, valB, dbg_data;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [1:0]  stat;

    int n_vec = 0;
    int n_err = 0;

    decode_writeback #(
        .DATA_W   (64),
        .RSP_INIT (RspInit)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .icode       (icode),
        .rA          (rA),
        .rB          (rB),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem_error  (dmem_error),
        .cnd         (cnd),
        .valE        (valE),
        .valM        (valM),
        .valA        (valA),
        .valB        (valB),
        .srcA        (srcA),
        .srcB        (srcB),
        .dstE        (dstE),
        .dstM        (dstM),
        .stat        (stat),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm);
        icode = ic; rA = ra; rB = rb; valE = ve; valM = vm;
        #1;
    endtask

    task automatic peek(input string tag, input logic [3:0] id, input logic [63:0] exp);
        dbg_addr = id;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
        instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0; cnd = 1'b0;
        valE = '0; valM = '0; dbg_addr = 4'h0;
        #12 rst_n = 1'b1;
        #1;

        // Reset contents
        for (int i = 0; i < 15; i++) begin
            peek($sformatf("reset_r%0d", i), 4'(i), (i == 4) ? RspInit : 64'h0);
        end
        peek("reset_rF", 4'hF, 64'h0);
        check("reset_stat", 64'(stat), 64'h0);

        // irmovq $0x64, %rdx
        instr(4'h3, 4'hF, 4'h2, 64'h64, 64'h0);
        check("irm_dstE", 64'(dstE), 64'h2);
        check("irm_dstM", 64'(dstM), 64'hF);
        check("irm_srcA", 64'(srcA), 64'hF);
        check("irm_srcB", 64'(srcB), 64'hF);
        tick();
        peek("irm_r2", 4'h2, 64'h64);

        // irmovq $1, %rcx
        instr(4'h3, 4'hF, 4'h1, 64'h1, 64'h0);
        tick();
        peek("irm_r1", 4'h1, 64'h1);

        // OPq %rcx, %rdx
        instr(4'h6, 4'h1, 4'h2, 64'h65, 64'h0);
        check("op_valA", valA, 64'h1);
        check("op_valB", valB, 64'h64);
        check("op_dstE", 64'(dstE), 64'h2);
        tick();
        peek("op_r2", 4'h2, 64'h65);

        // cmovXX not taken
        cnd = 1'b0;
        instr(4'h2, 4'h1, 4'h3, 64'h7, 64'h0);
        check("cmov0_dstE", 64'(dstE), 64'hF);
        check("cmov0_srcA", 64'(srcA), 64'h1);
        tick();
        peek("cmov0_r3", 4'h3, 64'h0);

        // cmovXX taken
        cnd = 1'b1;
        instr(4'h2, 4'h1, 4'h3, 64'h5, 64'h0);
        check("cmov1_dstE", 64'(dstE), 64'h3);
        tick();
        peek("cmov1_r3", 4'h3, 64'h5);
        cnd = 1'b0;

        // popq %rsp: M beats E on the same destination
        instr(4'hB, 4'h4, 4'hF, 64'hF08, 64'hAA);
        check("pop_srcA", 64'(srcA), 64'h4);
        check("pop_srcB", 64'(srcB), 64'h4);
        check("pop_dstE", 64'(dstE), 64'h4);
        check("pop_dstM", 64'(dstM), 64'h4);
        check("pop_valA", valA, RspInit);
        tick();
        peek("pop_r4", 4'h4, 64'hAA);

        // halt, then a later write is suppressed
        instr(4'h0, 4'hF, 4'hF, 64'h123, 64'h456);
        check("halt_pre_stat", 64'(stat), 64'h0);
        tick();
        check("halt_stat", 64'(stat), 64'h1);
        instr(4'h3, 4'hF, 4'h5, 64'h55, 64'h0);
        check("halted_dstE", 64'(dstE), 64'h5);
        tick();
        peek("halted_r5", 4'h5, 64'h0);
        check("halted_stat", 64'(stat), 64'h1);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("arst_stat", 64'(stat), 64'h0);
        peek("arst_r2", 4'h2, 64'h0);
        peek("arst_r4", 4'h4, RspInit);
        rst_n = 1'b1;

        // Fetch address error on OPq blocks its write
        instr(4'h3, 4'hF, 4'h2, 64'h77, 64'h0);
        tick();
        peek("pre_adr_r2", 4'h2, 64'h77);
        imem_error = 1'b1;
        instr(4'h6, 4'h1, 4'h2, 64'h99, 64'h0);
        tick();
        check("adr_stat", 64'(stat), 64'h2);
        peek("adr_r2", 4'h2, 64'h77);
        imem_error = 1'b0;

        // Invalid instruction after a fresh reset; error beats invalid is covered next
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        instr_valid = 1'b0;
        instr(4'hC, 4'h1, 4'h2, 64'h11, 64'h22);
        check("ins_srcA", 64'(srcA), 64'hF);
        check("ins_dstE", 64'(dstE), 64'hF);
        tick();
        check("ins_stat", 64'(stat), 64'h3);

        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        dmem_error = 1'b1;
        instr(4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        tick();
        check("dmem_prio_stat", 64'(stat), 64'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
